handshake_rx: RTL and testbench
===============================

# handshake_rx

Parametrised, single-clock receiver for a four-phase req/ack handshake carrying NCH independent register vectors from a foreign clock domain into `i_clk`. Each channel synchronises its incoming request, captures the held data, and drives a registered acknowledge back to the sender. The block sits at the destination side of every configuration/status crossing in the breakout firmware, so senders only need a request/acknowledge FSM.

## Interface
- `WIDTH`, 8, data bits per channel
- `NCH`, 4, number of independent channels
- `SYNC_STAGES`, 2, request synchroniser depth; legal range 2..4
- `RESET_VALUE`, 0, per-channel reset value of `o_data` (WIDTH bits, same for all channels)
- `TIMEOUT_CYCLES`, 1024, timeout threshold (used only with `HANDSHAKE_RX_TIMEOUT_EN`)

Ports:
- `i_clk`  in  1  receiver clock
- `i_rst`  in  1  asynchronous, active-high reset
- `i_req`  in  NCH  per-channel request from the foreign domain (asynchronous to `i_clk`)
- `i_data`  in  NCH*WIDTH  packed channel data, channel c at bits [c*WIDTH +: WIDTH]; held stable by the sender while its req is high
- `i_hold`  in  NCH  per-channel stall; while high, a pending request is not accepted
- `o_ack`  out  NCH  per-channel acknowledge to the sender, driven directly from a flop
- `o_data`  out  NCH*WIDTH  captured data
- `o_valid`  out  NCH  one-cycle pulse per capture
- `o_changed`  out  NCH  one-cycle pulse, coincident with `o_valid`, when the captured value differs from the previous `o_data`
- `o_timeout`  out  NCH  sticky timeout flag (tied 0 without the macro)
- `i_clr_timeout`  in  NCH  clears the corresponding `o_timeout`

## Operation
- Per channel: a `SYNC_STAGES` flop chain on `i_req[c]` produces `req_s`. `i_data` is never synchronised; the protocol guarantees it is stable.
- FSM states:
  - `IDLE` (ack=0): if `req_s && !i_hold[c]`, go to `ACK`, latch `i_data[c]` into `o_data[c]`, pulse `o_valid[c]`, and pulse `o_changed[c]` if the new value differs from the old one. If `i_hold[c]` is high, stay in `IDLE`.
  - `ACK` (ack=1): wait for `req_s == 0`, then return to `IDLE` with ack=0.
- `o_ack[c]` is high exactly in `ACK`.
- Channels are fully independent; simultaneous captures on any subset are legal.
- A req that rises, then falls before capture, while held, is lost. This is legal only as a sender protocol violation; the receiver does not recover it.
- `i_hold` asserted while in `ACK` has no effect.
- Reset, any time:
  - `o_data` = `RESET_VALUE`; `o_ack`, `o_valid`, `o_changed`, `o_timeout` = 0; sync chains = 0; FSM = `IDLE`.
  - If `req` is still high after reset, it is treated as a new transfer and recaptured. Senders tolerate the duplicate.

## Timing
- The edge that first samples `req=1` is edge 0. `req_s` is high after edge `SYNC_STAGES-1`.
- At edge `SYNC_STAGES`, `o_ack`, `o_data` and `o_valid` update together. Latency from sample to capture is `SYNC_STAGES` edges.
- `o_valid` and `o_changed` are high for exactly one cycle.
- Ack release: `req=0` is first sampled at edge k; `o_ack` falls at edge k+`SYNC_STAGES`.
- With `i_hold` released at edge h while `req_s` is high, capture happens at edge h+1.
- Minimum receiver-side round trip per transfer: 2×`SYNC_STAGES`+2 `i_clk` cycles.

## Configuration
- `HANDSHAKE_RX_TIMEOUT_EN` defined:
  - Each channel has a counter of `$clog2(TIMEOUT_CYCLES+1)` bits, cleared on entry to `ACK` and incremented each cycle in `ACK`, saturating at `TIMEOUT_CYCLES`.
  - When it reaches `TIMEOUT_CYCLES`, `o_timeout[c]` sets (sticky) and the FSM forces `IDLE` with ack=0.
  - `i_clr_timeout[c]` clears the flag. If set and clear occur in the same cycle, set wins.
- Not defined: no counter is built, `o_timeout` is tied to 0, and `i_clr_timeout` is ignored.

## Structure
- Package `handshake_pkg`:
  - FSM state encoding (`HS_IDLE`, `HS_ACK`)
  - default `SYNC_STAGES` constant
  - min/max sync-depth constants for elaboration checks
- Sub-module `handshake_rx_channel`: one channel's synchroniser, FSM, capture register and timeout counter. The top level is a generate loop over NCH plus port packing.

## Test plan
- Single transfer, WIDTH=8, SYNC_STAGES=2: ch0 req↑ with data 0xA5 → `o_data[0]`=0xA5, `o_valid[0]` and `o_changed[0]` pulse and `o_ack[0]`↑ at edge 2; req↓ → ack↓ 2 edges after it is sampled.
- Repeat 0xA5 then 0x3C on ch1 → `o_valid` pulses twice; `o_changed` on the second capture only.
- All 4 channels req↑ on the same edge with distinct data → four simultaneous captures, each lane correct, no cross-channel corruption.
- Hold ch2 for 10 cycles with req pending → no ack or valid during the hold; capture one edge after release.
- Assert `i_rst` while ch3 is in `ACK` with req still high → all outputs reach reset values immediately; after release, ch3 recaptures and `o_data[3]` briefly shows `RESET_VALUE` first.
- With `HANDSHAKE_RX_TIMEOUT_EN` and TIMEOUT_CYCLES=16, hold req high → `o_timeout[0]` sets after 16 cycles in `ACK` and ack drops; `i_clr_timeout[0]` clears the flag.

Source files
------------

// File: rtl/handshake_pkg.sv
`default_nettype none
// ============================================================================
// handshake_pkg : shared FSM encoding and sync-depth limits for handshake_rx
// Revision      : 1.0
// ============================================================================
package handshake_pkg;

    typedef enum logic [0:0] {
        HS_IDLE = 1'b0,
        HS_ACK  = 1'b1
    } hs_state_e;

    localparam int c_default_sync_stages = 2;
    localparam int c_min_sync_stages     = 2;
    localparam int c_max_sync_stages     = 4;

endpackage
`default_nettype wire

// File: rtl/handshake_rx_channel.sv
`default_nettype none
// ============================================================================
// handshake_rx_channel : one four-phase req/ack receiver lane (sync, FSM, capture)
// Optional timeout watchdog enabled by HANDSHAKE_RX_TIMEOUT_EN
// Revision             : 1.0
// ============================================================================
module handshake_rx_channel
    import handshake_pkg::*;
#(
    parameter int               WIDTH          = 8,
    parameter int               SYNC_STAGES    = c_default_sync_stages,
    parameter logic [WIDTH-1:0] RESET_VALUE    = '0,
    parameter int               TIMEOUT_CYCLES = 1024
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_req,
    input  logic [WIDTH-1:0] i_data,
    input  logic             i_hold,
    input  logic             i_clr_timeout,
    output logic             o_ack,
    output logic [WIDTH-1:0] o_data,
    output logic             o_valid,
    output logic             o_changed,
    output logic             o_timeout
);

    if (SYNC_STAGES < c_min_sync_stages || SYNC_STAGES > c_max_sync_stages) begin : g_bad_sync
        $error("handshake_rx_channel: SYNC_STAGES out of range");
    end
    if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
        $error("handshake_rx_channel: TIMEOUT_CYCLES must be at least 1");
    end

    logic [SYNC_STAGES-1:0] sync_q;
    hs_state_e              state_q, state_d;
    logic [WIDTH-1:0]       data_q, data_d;
    logic                   valid_q, valid_d;
    logic                   changed_q, changed_d;
    logic                   req_s;
    logic                   timeout_hit;

    assign req_s = sync_q[SYNC_STAGES-1];

    always_comb begin
        state_d   = state_q;
        data_d    = data_q;
        valid_d   = 1'b0;
        changed_d = 1'b0;
        case (state_q)
            HS_IDLE: begin
                if (req_s && !i_hold) begin
                    state_d   = HS_ACK;
                    data_d    = i_data;
                    valid_d   = 1'b1;
                    changed_d = (i_data != data_q);
                end
            end
            HS_ACK: begin
                if (!req_s || timeout_hit) begin
                    state_d = HS_IDLE;
                end
            end
            default: state_d = HS_IDLE;
        endcase
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            sync_q    <= '0;
            state_q   <= HS_IDLE;
            data_q    <= RESET_VALUE;
            valid_q   <= 1'b0;
            changed_q <= 1'b0;
        end else begin
            sync_q    <= {sync_q[SYNC_STAGES-2:0], i_req};
            state_q   <= state_d;
            data_q    <= data_d;
            valid_q   <= valid_d;
            changed_q <= changed_d;
        end
    end

`ifdef HANDSHAKE_RX_TIMEOUT_EN
    localparam int             CW        = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CW-1:0]  c_cnt_max = CW'(TIMEOUT_CYCLES);
    localparam logic [CW-1:0]  c_cnt_hit = CW'(TIMEOUT_CYCLES - 1);

    logic [CW-1:0] cnt_q, cnt_d;
    logic          timeout_q, timeout_d;

    // The count lands on TIMEOUT_CYCLES on the same edge that forces IDLE.
    assign timeout_hit = (state_q == HS_ACK) && (cnt_q == c_cnt_hit);

    always_comb begin
        cnt_d     = cnt_q;
        timeout_d = timeout_q;
        if (state_q == HS_IDLE) begin
            cnt_d = '0;
        end else if (cnt_q != c_cnt_max) begin
            cnt_d = cnt_q + CW'(1);
        end
        if (timeout_hit) begin
            timeout_d = 1'b1;
        end else if (i_clr_timeout) begin
            timeout_d = 1'b0;
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            cnt_q     <= '0;
            timeout_q <= 1'b0;
        end else begin
            cnt_q     <= cnt_d;
            timeout_q <= timeout_d;
        end
    end

    assign o_timeout = timeout_q;
`else
    logic unused_clr_timeout;
    assign unused_clr_timeout = i_clr_timeout;
    assign timeout_hit        = 1'b0;
    assign o_timeout          = 1'b0;
`endif

    assign o_ack     = (state_q == HS_ACK);
    assign o_data    = data_q;
    assign o_valid   = valid_q;
    assign o_changed = changed_q;

endmodule
`default_nettype wire

// File: rtl/handshake_rx.sv
`default_nettype none
// ============================================================================
// handshake_rx : NCH independent four-phase req/ack receivers into i_clk
// Optional per-channel timeout watchdog enabled by HANDSHAKE_RX_TIMEOUT_EN
// Revision     : 1.0
// ============================================================================
module handshake_rx
    import handshake_pkg::*;
#(
    parameter int               WIDTH          = 8,
    parameter int               NCH            = 4,
    parameter int               SYNC_STAGES    = c_default_sync_stages,
    parameter logic [WIDTH-1:0] RESET_VALUE    = '0,
    parameter int               TIMEOUT_CYCLES = 1024
) (
    input  logic                 i_clk,
    input  logic                 i_rst,
    input  logic [NCH-1:0]       i_req,
    input  logic [NCH*WIDTH-1:0] i_data,
    input  logic [NCH-1:0]       i_hold,
    output logic [NCH-1:0]       o_ack,
    output logic [NCH*WIDTH-1:0] o_data,
    output logic [NCH-1:0]       o_valid,
    output logic [NCH-1:0]       o_changed,
    output logic [NCH-1:0]       o_timeout,
    input  logic [NCH-1:0]       i_clr_timeout
);

    for (genvar c = 0; c < NCH; c++) begin : g_ch
        handshake_rx_channel #(
            .WIDTH          (WIDTH),
            .SYNC_STAGES    (SYNC_STAGES),
            .RESET_VALUE    (RESET_VALUE),
            .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
        ) u_ch (
            .i_clk         (i_clk),
            .i_rst         (i_rst),
            .i_req         (i_req[c]),
            .i_data        (i_data[c*WIDTH +: WIDTH]),
            .i_hold        (i_hold[c]),
            .i_clr_timeout (i_clr_timeout[c]),
            .o_ack         (o_ack[c]),
            .o_data        (o_data[c*WIDTH +: WIDTH]),
            .o_valid       (o_valid[c]),
            .o_changed     (o_changed[c]),
            .o_timeout     (o_timeout[c])
        );
    end

endmodule
`default_nettype wire

// File: tb/tb_handshake_rx.sv
`default_nettype none
// ============================================================================
// tb_handshake_rx : directed table, corner sequences and randomized model check
// Revision        : 1.0
// ============================================================================
module tb_handshake_rx;

    localparam int         W  = 8;
    localparam int         N  = 4;
    localparam int         SS = 2;
    localparam int         TO = 16;
    localparam logic [7:0] RV = 8'hC3;

    logic           clk = 1'b0;
    logic           rst = 1'b1;
    logic [N-1:0]   req = '0;
    logic [N*W-1:0] data = '0;
    logic [N-1:0]   hold = '0;
    logic [N-1:0]   clr = '0;
    logic [N-1:0]   ack, valid, changed, tmo;
    logic [N*W-1:0] odata;

    int checks = 0;
    int errors = 0;

    handshake_rx #(
        .WIDTH(W), .NCH(N), .SYNC_STAGES(SS), .RESET_VALUE(RV), .TIMEOUT_CYCLES(TO)
    ) dut (
        .i_clk(clk), .i_rst(rst), .i_req(req), .i_data(data), .i_hold(hold),
        .o_ack(ack), .o_data(odata), .o_valid(valid), .o_changed(changed),
        .o_timeout(tmo), .i_clr_timeout(clr)
    );

    always #5 clk = ~clk;

    typedef struct {
        int         ch;
        logic       req;
        logic [7:0] d;
        logic       e_ack;
        logic       e_valid;
        logic       e_changed;
        logic [7:0] e_data;
    } vec_t;

    vec_t tbl[$];

    // Model of the receiver: req history, acknowledge flag and held value per lane.
    logic [31:0] m_hist [N];
    logic        m_ack  [N];
    logic [7:0]  m_od   [N];
    logic        m_v    [N];
    logic        m_c    [N];
    logic        m_to   [N];
    int          m_cnt  [N];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic void push_xfer(int ch, logic [7:0] d, logic [7:0] prev, logic chg);
        for (int i = 0; i < 7; i++) begin
            vec_t v;
            v.ch        = ch;
            v.req       = (i < 4);
            v.d         = d;
            v.e_ack     = (i >= 2 && i < 6);
            v.e_valid   = (i == 2);
            v.e_changed = (i == 2) && chg;
            v.e_data    = (i >= 2) ? d : prev;
            tbl.push_back(v);
        end
    endfunction

    task automatic model_reset();
        for (int c = 0; c < N; c++) begin
            m_hist[c] = '0; m_ack[c] = 1'b0; m_od[c] = RV;
            m_v[c] = 1'b0; m_c[c] = 1'b0; m_to[c] = 1'b0; m_cnt[c] = 0;
        end
    endtask

    // Called just before an edge: consumes the inputs that edge will sample.
    task automatic model_step();
        for (int c = 0; c < N; c++) begin
            logic       rs;
            logic       expired;
            logic [7:0] d;
            rs        = m_hist[c][SS-1];
            m_hist[c] = {m_hist[c][30:0], req[c]};
            d         = data[c*W +: W];
            expired   = 1'b0;
            m_v[c]    = 1'b0;
            m_c[c]    = 1'b0;
            if (!m_ack[c]) begin
                if (rs && !hold[c]) begin
                    m_ack[c] = 1'b1;
                    m_v[c]   = 1'b1;
                    m_c[c]   = (d != m_od[c]);
                    m_od[c]  = d;
                    m_cnt[c] = 0;
                end
            end else begin
`ifdef HANDSHAKE_RX_TIMEOUT_EN
                m_cnt[c]++;
                expired = (m_cnt[c] >= TO);
`endif
                if (expired || !rs) m_ack[c] = 1'b0;
            end
            if (expired) m_to[c] = 1'b1;
            else if (clr[c]) m_to[c] = 1'b0;
`ifndef HANDSHAKE_RX_TIMEOUT_EN
            m_to[c] = 1'b0;
`endif
        end
    endtask

    initial begin
        logic [N-1:0]   e_ack, e_v, e_c, e_t;
        logic [N*W-1:0] e_d;

        // ---------------- reset state ----------------
        tick(); tick();
        chk("reset_ack", 32'(ack), 32'h0);
        chk("reset_valid", 32'(valid), 32'h0);
        chk("reset_changed", 32'(changed), 32'h0);
        chk("reset_timeout", 32'(tmo), 32'h0);
        chk("reset_data", odata, {N{RV}});
        rst = 1'b0;

        // ---------------- table: single transfer and repeat/change ----------------
        push_xfer(0, 8'hA5, RV, 1'b1);
        push_xfer(1, 8'hA5, RV, 1'b1);
        push_xfer(1, 8'hA5, 8'hA5, 1'b0);
        push_xfer(1, 8'h3C, 8'hA5, 1'b1);
        foreach (tbl[i]) begin
            req = '0;
            req[tbl[i].ch] = tbl[i].req;
            data[tbl[i].ch*W +: W] = tbl[i].d;
            tick();
            chk($sformatf("tbl%0d_ack", i), 32'(ack[tbl[i].ch]), 32'(tbl[i].e_ack));
            chk($sformatf("tbl%0d_valid", i), 32'(valid[tbl[i].ch]), 32'(tbl[i].e_valid));
            chk($sformatf("tbl%0d_changed", i), 32'(changed[tbl[i].ch]), 32'(tbl[i].e_changed));
            chk($sformatf("tbl%0d_data", i), 32'(odata[tbl[i].ch*W +: W]), 32'(tbl[i].e_data));
        end

        // ---------------- all channels at once ----------------
        req = '1;
        data = 32'h44332211;
        tick(); tick();
        chk("all_pre_valid", 32'(valid), 32'h0);
        tick();
        chk("all_valid", 32'(valid), 32'hF);
        chk("all_ack", 32'(ack), 32'hF);
        chk("all_data", odata, 32'h44332211);
        chk("all_changed", 32'(changed), 32'hF);
        req = '0;
        tick(); tick(); tick();
        chk("all_ack_release", 32'(ack), 32'h0);

        // ---------------- hold ch2 with request pending ----------------
        hold[2] = 1'b1;
        req[2]  = 1'b1;
        data[2*W +: W] = 8'h77;
        for (int i = 0; i < 10; i++) begin
            tick();
            chk("hold_ack", 32'(ack[2]), 32'h0);
            chk("hold_valid", 32'(valid[2]), 32'h0);
        end
        hold[2] = 1'b0;
        tick();
        chk("hold_release_valid", 32'(valid[2]), 32'h1);
        chk("hold_release_ack", 32'(ack[2]), 32'h1);
        chk("hold_release_data", 32'(odata[2*W +: W]), 32'h77);
        hold[2] = 1'b1;
        tick();
        chk("hold_in_ack_no_effect", 32'(ack[2]), 32'h1);
        hold[2] = 1'b0;
        req[2]  = 1'b0;
        tick(); tick(); tick();
        chk("hold_ack_release", 32'(ack[2]), 32'h0);

        // ---------------- async reset while ch3 is in ACK ----------------
        req[3] = 1'b1;
        data[3*W +: W] = 8'h99;
        tick(); tick(); tick();
        chk("rst_pre_ack", 32'(ack[3]), 32'h1);
        #2 rst = 1'b1;
        #1;
        chk("rst_async_ack", 32'(ack), 32'h0);
        chk("rst_async_data", odata, {N{RV}});
        chk("rst_async_valid", 32'(valid), 32'h0);
        @(posedge clk);
        #1 rst = 1'b0;
        tick(); tick();
        chk("rst_recap_old", 32'(odata[3*W +: W]), 32'(RV));
        chk("rst_recap_noack", 32'(ack[3]), 32'h0);
        tick();
        chk("rst_recap_valid", 32'(valid[3]), 32'h1);
        chk("rst_recap_data", 32'(odata[3*W +: W]), 32'h99);
        req[3] = 1'b0;
        tick(); tick(); tick();
        chk("rst_recap_release", 32'(ack[3]), 32'h0);

`ifdef HANDSHAKE_RX_TIMEOUT_EN
        // ---------------- timeout on a stuck request ----------------
        req[0] = 1'b1;
        data[0*W +: W] = 8'h5E;
        tick(); tick(); tick();
        chk("to_entry_ack", 32'(ack[0]), 32'h1);
        for (int i = 0; i < TO - 1; i++) tick();
        chk("to_before_ack", 32'(ack[0]), 32'h1);
        chk("to_before_flag", 32'(tmo[0]), 32'h0);
        tick();
        chk("to_hit_ack", 32'(ack[0]), 32'h0);
        chk("to_hit_flag", 32'(tmo[0]), 32'h1);
        req[0] = 1'b0;
        clr[0] = 1'b1;
        tick();
        clr[0] = 1'b0;
        chk("to_clear_flag", 32'(tmo[0]), 32'h0);
        tick(); tick(); tick();
        chk("to_final_ack", 32'(ack[0]), 32'h0);
`endif

        // ---------------- randomized run against the model ----------------
        req = '0; hold = '0; clr = '0;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        model_reset();
        for (int cyc = 0; cyc < 800; cyc++) begin
            for (int c = 0; c < N; c++) begin
                if (!req[c] && !ack[c]) begin
                    if ($urandom_range(0, 2) == 0) begin
                        req[c] = 1'b1;
                        data[c*W +: W] = 8'(($urandom_range(0, 3) << 6) | 8'h11);
                    end
                end else if (req[c] && ack[c]) begin
                    if ($urandom_range(0, 1) == 0) req[c] = 1'b0;
                end
                hold[c] = ($urandom_range(0, 3) == 0);
                clr[c]  = ($urandom_range(0, 7) == 0);
            end
            model_step();
            tick();
            for (int c = 0; c < N; c++) begin
                e_ack[c] = m_ack[c];
                e_v[c]   = m_v[c];
                e_c[c]   = m_c[c];
                e_t[c]   = m_to[c];
                e_d[c*W +: W] = m_od[c];
            end
            chk("rnd_ack", 32'(ack), 32'(e_ack));
            chk("rnd_valid", 32'(valid), 32'(e_v));
            chk("rnd_changed", 32'(changed), 32'(e_c));
            chk("rnd_timeout", 32'(tmo), 32'(e_t));
            chk("rnd_data", odata, e_d);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
